// File: rtl/board_state_pkg.sv
// Shared chess encodings: square/piece widths, piece-type codes, sequencer
// states and the opening-position lookup used on reset and new game.
package board_state_pkg;

  localparam int SQ_W    = 6;
  localparam int PIECE_W = 4;
  localparam int NUM_SQ  = 64;

  localparam logic [PIECE_W-1:0] EMPTY = 4'h0;
  localparam logic               BLACK = 1'b1;
  localparam logic               WHITE = 1'b0;

  localparam logic [2:0] T_PAWN   = 3'd1;
  localparam logic [2:0] T_KNIGHT = 3'd2;
  localparam logic [2:0] T_BISHOP = 3'd3;
  localparam logic [2:0] T_ROOK   = 3'd4;
  localparam logic [2:0] T_QUEEN  = 3'd5;
  localparam logic [2:0] T_KING   = 3'd6;

  typedef enum logic [2:0] {IDLE, MV_CLR, MV_SET, UN_DST, UN_SRC} seqState_t;

  // Square address is {rank, file}; rank 0 is the white home rank.
  function automatic logic [PIECE_W-1:0] initSquare(input logic [SQ_W-1:0] sq);
    logic [2:0] rank;
    logic [2:0] file;
    logic [2:0] backType;
    rank = sq[5:3];
    file = sq[2:0];
    case (file)
      3'd0, 3'd7: backType = T_ROOK;
      3'd1, 3'd6: backType = T_KNIGHT;
      3'd2, 3'd5: backType = T_BISHOP;
      3'd3:       backType = T_QUEEN;
      default:    backType = T_KING;
    endcase
    case (rank)
      3'd0:    initSquare = {WHITE, backType};
      3'd1:    initSquare = {WHITE, T_PAWN};
      3'd6:    initSquare = {BLACK, T_PAWN};
      3'd7:    initSquare = {BLACK, backType};
      default: initSquare = EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/board_state_if.sv
// Board port bundle: game_logic/display side drives "master", board_state
// holds the "slave" view.
interface board_state_if;
  import board_state_pkg::*;

  logic                      new_game;
  logic                      wr_en;
  logic [SQ_W-1:0]           wr_addr;
  logic [PIECE_W-1:0]        wr_piece;
  logic                      mv_req;
  logic [SQ_W-1:0]           mv_src;
  logic [SQ_W-1:0]           mv_dst;
  logic                      undo_req;
  logic                      mv_busy;
  logic                      mv_done;
  logic [PIECE_W-1:0]        captured;
  logic                      undo_valid;
  logic [NUM_SQ*PIECE_W-1:0] board_flat;
  logic [SQ_W-1:0]           rd_addr;
  logic [PIECE_W-1:0]        rd_piece;

  modport master (
    output new_game, wr_en, wr_addr, wr_piece, mv_req, mv_src, mv_dst,
           undo_req, rd_addr,
    input  mv_busy, mv_done, captured, undo_valid, board_flat, rd_piece
  );

  modport slave (
    input  new_game, wr_en, wr_addr, wr_piece, mv_req, mv_src, mv_dst,
           undo_req, rd_addr,
    output mv_busy, mv_done, captured, undo_valid, board_flat, rd_piece
  );
endinterface

// File: rtl/board_state.sv
// 64-square board register with a two-step move/undo sequencer, direct
// square writes, new-game load and a registered display read port.
module board_state
  import board_state_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  board_state_if.slave bus
);

  logic [PIECE_W-1:0] board [NUM_SQ];
  seqState_t          state;
  logic [SQ_W-1:0]    srcSq;
  logic [SQ_W-1:0]    dstSq;
  logic [PIECE_W-1:0] movedPc;
  logic [PIECE_W-1:0] capPc;
  logic               mvDone;
  logic [PIECE_W-1:0] capturedQ;
  logic               undoValid;
  logic [PIECE_W-1:0] rdPiece;

  // The latched move operands double as the undo record: a newer move only
  // overwrites them once it is underway, and an aborted one clears undoValid.
  always_ff @(posedge Clk) begin
    if (Reset || bus.new_game) begin
      for (int i = 0; i < NUM_SQ; i++) board[i] <= initSquare(SQ_W'(i));
      state     <= IDLE;
      mvDone    <= 1'b0;
      capturedQ <= EMPTY;
      undoValid <= 1'b0;
      rdPiece   <= EMPTY;
    end else begin
      rdPiece <= board[bus.rd_addr];
      mvDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mv_req) begin
            if (bus.mv_src != bus.mv_dst) begin
              srcSq   <= bus.mv_src;
              dstSq   <= bus.mv_dst;
              movedPc <= board[bus.mv_src];
              capPc   <= board[bus.mv_dst];
              state   <= MV_CLR;
            end else begin
              mvDone <= 1'b1;
            end
          end else if (bus.undo_req) begin
            if (undoValid) state <= UN_DST;
          end else if (bus.wr_en) begin
            board[bus.wr_addr] <= bus.wr_piece;
            undoValid          <= 1'b0;
          end
        end
        MV_CLR: begin
          board[srcSq] <= EMPTY;
          state        <= MV_SET;
        end
        MV_SET: begin
          board[dstSq] <= movedPc;
          capturedQ    <= capPc;
          undoValid    <= 1'b1;
          mvDone       <= 1'b1;
          state        <= IDLE;
        end
        UN_DST: begin
          board[dstSq] <= capPc;
          state        <= UN_SRC;
        end
        UN_SRC: begin
          board[srcSq] <= movedPc;
          undoValid    <= 1'b0;
          capturedQ    <= EMPTY;
          mvDone       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SQ; g++) begin : gFlat
    assign bus.board_flat[PIECE_W*g +: PIECE_W] = board[g];
  end

  assign bus.mv_busy    = (state != IDLE);
  assign bus.mv_done    = mvDone;
  assign bus.captured   = capturedQ;
  assign bus.undo_valid = undoValid;
  assign bus.rd_piece   = rdPiece;

endmodule

// File: tb/tb_board_state.sv
// Randomized bench for board_state: a timeline model of the board checked
// every cycle, plus directed literal checks of the key scenarios.
module tb_board_state;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  board_state_if bus();
  board_state dut (.Clk(clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [255:0] opening();
    logic [2:0] back [8];
    logic [255:0] b;
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    b = '0;
    for (int f = 0; f < 8; f++) begin
      b[4*f      +: 4] = {1'b0, back[f]};
      b[4*(8+f)  +: 4] = 4'h1;
      b[4*(48+f) +: 4] = 4'h9;
      b[4*(56+f) +: 4] = {1'b1, back[f]};
    end
    return b;
  endfunction

  function automatic logic [3:0] getSq(logic [255:0] b, int sq);
    return b[4*sq +: 4];
  endfunction

  function automatic logic [255:0] putSq(logic [255:0] b, int sq, logic [3:0] p);
    logic [255:0] r;
    r = b;
    r[4*sq +: 4] = p;
    return r;
  endfunction

  // The visible board follows a timeline: an accepted move/undo precomputes
  // its intermediate and final boards, which appear on the next two edges.
  logic [255:0] mVis, mMid, mFin;
  int           left = 0;
  bit           modelOn = 0;
  bit           mDone, mUndoOk, pendIsMove;
  logic [3:0]   mCap, mRd, pendCap;
  int           pSrc, pDst, rSrc, rDst;
  logic [3:0]   pMoved, pTaken, rMoved, rTaken;

  always @(posedge clk) begin
    if (Reset || bus.new_game) begin
      mVis = opening(); left = 0; mDone = 0; mCap = 0; mUndoOk = 0; mRd = 0;
      modelOn = 1;
    end else if (modelOn) begin
      mRd   = getSq(mVis, int'(bus.rd_addr));
      mDone = 0;
      if (left == 2) begin
        mVis = mMid; left = 1;
      end else if (left == 1) begin
        mVis = mFin; left = 0; mDone = 1; mCap = pendCap;
        if (pendIsMove) begin
          mUndoOk = 1; rSrc = pSrc; rDst = pDst; rMoved = pMoved; rTaken = pTaken;
        end else mUndoOk = 0;
      end else if (bus.mv_req) begin
        if (bus.mv_src == bus.mv_dst) mDone = 1;
        else begin
          pSrc = int'(bus.mv_src); pDst = int'(bus.mv_dst);
          pMoved = getSq(mVis, pSrc); pTaken = getSq(mVis, pDst);
          mMid = putSq(mVis, pSrc, 4'h0);
          mFin = putSq(mMid, pDst, pMoved);
          pendCap = pTaken; pendIsMove = 1; left = 2;
        end
      end else if (bus.undo_req) begin
        if (mUndoOk) begin
          mMid = putSq(mVis, rDst, rTaken);
          mFin = putSq(mMid, rSrc, rMoved);
          pendCap = 4'h0; pendIsMove = 0; left = 2;
        end
      end else if (bus.wr_en) begin
        mVis = putSq(mVis, int'(bus.wr_addr), bus.wr_piece);
        mUndoOk = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      chk("board_flat", bus.board_flat, mVis);
      chk("mv_busy", 256'(bus.mv_busy), 256'(left != 0));
      chk("mv_done", 256'(bus.mv_done), 256'(mDone));
      chk("captured", 256'(bus.captured), 256'(mCap));
      chk("undo_valid", 256'(bus.undo_valid), 256'(mUndoOk));
      chk("rd_piece", 256'(bus.rd_piece), 256'(mRd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clearIn();
    bus.new_game = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_piece = 0;
    bus.mv_req = 0; bus.mv_src = 0; bus.mv_dst = 0; bus.undo_req = 0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(int s, int d);
    bus.mv_req = 1; bus.mv_src = 6'(s); bus.mv_dst = 6'(d);
    tick(); bus.mv_req = 0;
  endtask

  function automatic logic [3:0] sqOf(int sq);
    return bus.board_flat[4*sq +: 4];
  endfunction

  initial begin
    Reset = 1; bus.rd_addr = 0; clearIn();
    tick(2);
    Reset = 0;
    chk("rst_a1_rook", 256'(sqOf(0)), 256'(4'h4));
    chk("rst_e1_king", 256'(sqOf(4)), 256'(4'h6));
    chk("rst_a8_rook", 256'(sqOf(56)), 256'(4'hC));
    chk("rst_e8_king", 256'(sqOf(60)), 256'(4'hE));
    chk("rst_sq27", 256'(sqOf(27)), 256'(4'h0));
    chk("rst_undo_valid", 256'(bus.undo_valid), 256'(1'b0));

    // e2 -> e4
    move(12, 28);
    tick();
    chk("e2e4_mid_src", 256'(sqOf(12)), 256'(4'h0));
    chk("e2e4_mid_dst", 256'(sqOf(28)), 256'(4'h0));
    tick();
    chk("e2e4_dst", 256'(sqOf(28)), 256'(4'h1));
    chk("e2e4_done", 256'(bus.mv_done), 256'(1'b1));
    chk("e2e4_cap", 256'(bus.captured), 256'(4'h0));
    chk("e2e4_undo_valid", 256'(bus.undo_valid), 256'(1'b1));

    // capture and undo
    bus.wr_en = 1; bus.wr_addr = 35; bus.wr_piece = 4'h9;
    tick(); bus.wr_en = 0;
    move(28, 35); tick(2);
    chk("cap_dst", 256'(sqOf(35)), 256'(4'h1));
    chk("cap_piece", 256'(bus.captured), 256'(4'h9));
    bus.undo_req = 1; tick(); bus.undo_req = 0; tick();
    chk("undo_done_early", 256'(bus.mv_done), 256'(1'b0));
    tick();
    chk("undo_sq28", 256'(sqOf(28)), 256'(4'h1));
    chk("undo_sq35", 256'(sqOf(35)), 256'(4'h9));
    chk("undo_valid_clr", 256'(bus.undo_valid), 256'(1'b0));

    // requests while busy are dropped
    move(8, 16);
    bus.mv_req = 1; bus.mv_src = 9; bus.mv_dst = 17;
    bus.wr_en = 1; bus.wr_addr = 40; bus.wr_piece = 4'h3;
    tick(); clearIn(); bus.undo_req = 1; tick(); bus.undo_req = 0;
    chk("busy_sq17", 256'(sqOf(17)), 256'(4'h0));
    chk("busy_sq40", 256'(sqOf(40)), 256'(4'h0));
    chk("busy_sq16", 256'(sqOf(16)), 256'(4'h1));
    bus.wr_en = 1; bus.wr_addr = 20; bus.wr_piece = 4'h7; tick(); bus.wr_en = 0;
    chk("wr_illegal_code", 256'(sqOf(20)), 256'(4'h7));
    bus.undo_req = 1; tick(); bus.undo_req = 0;
    chk("undo_ignored_busy", 256'(bus.mv_busy), 256'(1'b0));

    // new game mid-move, then null move
    move(1, 18);
    bus.new_game = 1; tick(); bus.new_game = 0;
    chk("ng_board", bus.board_flat, opening());
    chk("ng_busy", 256'(bus.mv_busy), 256'(1'b0));
    tick();
    chk("ng_no_done", 256'(bus.mv_done), 256'(1'b0));
    move(5, 5);
    chk("null_done", 256'(bus.mv_done), 256'(1'b1));
    chk("null_board", bus.board_flat, opening());

    bus.rd_addr = 4; tick();
    chk("rd_e1", 256'(bus.rd_piece), 256'(4'h6));
    tick(2);
    chk("rd_e1_hold", 256'(bus.rd_piece), 256'(4'h6));

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      Reset        = ($urandom_range(0, 399) == 0);
      bus.new_game = ($urandom_range(0, 99) == 0);
      bus.mv_req   = ($urandom_range(0, 4) == 0);
      bus.mv_src   = 6'($urandom_range(0, 63));
      bus.mv_dst   = ($urandom_range(0, 7) == 0) ? bus.mv_src : 6'($urandom_range(0, 63));
      bus.undo_req = ($urandom_range(0, 5) == 0);
      bus.wr_en    = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = 6'($urandom_range(0, 63));
      bus.wr_piece = 4'($urandom_range(0, 15));
      bus.rd_addr  = 6'($urandom_range(0, 63));
      tick();
    end
    Reset = 0; clearIn(); tick(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
